// File: rtl/differencer_binary_pkg.sv
// ----------------------------------------------------------------------------
// differencer_binary_pkg
//
// Purpose:
//   Shared definitions for the binary differencer slice. It holds the state
//   encodings of the output skid buffer and a small helper that tells whether
//   a given buffer state holds data.
//
// Contents:
//   skid_state_t       2-bit skid-buffer state type
//   SKID_EMPTY         no entries held          (valid=0, ready=1)
//   SKID_BUSY          output register holds    (valid=1, ready=1)
//   SKID_FULL          output + skid register   (valid=1, ready=0)
//   skid_holds_data()  1 when the state presents a valid output
// ----------------------------------------------------------------------------
package differencer_binary_pkg;

    typedef logic [1:0] skid_state_t;

    localparam skid_state_t SKID_EMPTY = 2'b00;
    localparam skid_state_t SKID_BUSY  = 2'b01;
    localparam skid_state_t SKID_FULL  = 2'b10;

    // The output side is valid in every state except EMPTY.
    function automatic logic skid_holds_data(input skid_state_t state);
        return (state != SKID_EMPTY);
    endfunction

endpackage

// File: rtl/differencer_binary_if.sv
// ----------------------------------------------------------------------------
// differencer_binary_if
//
// Purpose:
//   Groups the sample stream (into the differencer) and the difference stream
//   (out of the differencer) with their valid/ready handshakes.
//
// Parameters:
//   WORD_WIDTH            width of samples and differences
//
// Signals:
//   sample_in             signed input sample
//   sample_in_valid       sample offered by the producer
//   sample_in_ready       differencer can accept a sample
//   borrow_in             extra 1 subtracted, for chaining differencers
//   difference_out        sample minus reference minus borrow_in
//   difference_out_valid  difference offered to the consumer
//   difference_out_ready  consumer accepts the difference
//   borrow_out            unsigned borrow of the subtraction
//   signed_overflow       signed overflow of the subtraction
//
// Modports:
//   master  producer/consumer side (drives samples, accepts differences)
//   slave   differencer side
// ----------------------------------------------------------------------------
interface differencer_binary_if #(
    parameter int WORD_WIDTH = 8
);

    logic [WORD_WIDTH-1:0] sample_in;
    logic                  sample_in_valid;
    logic                  sample_in_ready;
    logic                  borrow_in;
    logic [WORD_WIDTH-1:0] difference_out;
    logic                  difference_out_valid;
    logic                  difference_out_ready;
    logic                  borrow_out;
    logic                  signed_overflow;

    modport master (
        output sample_in,
        output sample_in_valid,
        output borrow_in,
        output difference_out_ready,
        input  sample_in_ready,
        input  difference_out,
        input  difference_out_valid,
        input  borrow_out,
        input  signed_overflow
    );

    modport slave (
        input  sample_in,
        input  sample_in_valid,
        input  borrow_in,
        input  difference_out_ready,
        output sample_in_ready,
        output difference_out,
        output difference_out_valid,
        output borrow_out,
        output signed_overflow
    );

endinterface

// File: rtl/differencer_binary_skid.sv
// ----------------------------------------------------------------------------
// Pipeline_Skid_Buffer
//
// Purpose:
//   Two-entry output buffer between the differencer datapath and its
//   consumer. The output register feeds the consumer directly; the skid
//   register catches one extra word when the consumer stalls, so the
//   upstream ready can be a registered signal without losing data.
//
// Parameters:
//   DATA_WIDTH       payload width
//
// Ports:
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   clock_enable_i   low freezes all state and masks both handshakes
//   clear_i          synchronous flush; ready held low while asserted
//   in_data_i        payload to store
//   in_valid_i       payload offered
//   in_ready_o       buffer can accept (registered, masked by enable)
//   out_data_o       oldest stored payload
//   out_valid_o      out_data_o is valid (masked by enable)
//   out_ready_i      consumer accepts out_data_o
// ----------------------------------------------------------------------------
module Pipeline_Skid_Buffer
    import differencer_binary_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clock_enable_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    skid_state_t           state_q, state_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  inTransfer;
    logic                  outTransfer;

    // Both handshakes are masked by the enable so that a frozen block never
    // advertises a transfer it would not perform.
    assign in_ready_o  = ready_q & clock_enable_i;
    assign out_valid_o = skid_holds_data(state_q) & clock_enable_i;
    assign out_data_o  = main_q;

    assign inTransfer  = in_valid_i & in_ready_o;
    assign outTransfer = out_valid_o & out_ready_i;

    // Next-state logic. New data lands in the output register whenever it is
    // free or being drained in the same cycle; otherwise it goes to the skid
    // register. Draining a FULL buffer moves the skid entry forward, keeping
    // strict arrival order. Ready is computed from the next state so the
    // registered copy already reflects FULL when the skid entry is occupied.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        ready_d = 1'b0;

        if (clear_i) begin
            state_d = SKID_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (inTransfer) begin
                        main_d  = in_data_i;
                        state_d = SKID_BUSY;
                    end
                end
                SKID_BUSY: begin
                    if (inTransfer && !outTransfer) begin
                        skid_d  = in_data_i;
                        state_d = SKID_FULL;
                    end else if (!inTransfer && outTransfer) begin
                        state_d = SKID_EMPTY;
                    end else if (inTransfer && outTransfer) begin
                        main_d  = in_data_i;
                    end
                end
                SKID_FULL: begin
                    if (outTransfer) begin
                        main_d  = skid_q;
                        state_d = SKID_BUSY;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                end
            endcase
        end

        ready_d = !clear_i && (state_d != SKID_FULL);
    end

    // State registers; the enable holds everything, including a pending clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (clock_enable_i) begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/differencer_binary.sv
// ----------------------------------------------------------------------------
// differencer_binary
//
// Purpose:
//   Streaming first-difference unit. Each accepted sample is reduced by the
//   stored reference (the previous sample, or a loaded value) and by
//   borrow_in; the result, its unsigned borrow and its signed overflow flag
//   are queued in a two-entry skid buffer toward the consumer. The accepted
//   sample then becomes the new reference.
//
// Parameters:
//   WORD_WIDTH       sample/difference width, must be 2 or more
//   INITIAL_VALUE    reference value after reset or clear
//
// Ports:
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   clock_enable     low freezes all state and masks the handshakes
//   clear            synchronous return to INITIAL_VALUE, flushes the buffer
//   load_value       new reference value
//   load_valid       replaces the reference, produces no output
//   reference_value  currently stored reference
//   bus              sample/difference streams (differencer_binary_if.slave)
// ----------------------------------------------------------------------------
module differencer_binary
    import differencer_binary_pkg::*;
#(
    parameter int                    WORD_WIDTH    = 0,
    parameter logic [WORD_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clock_enable,
    input  logic                  clear,
    input  logic [WORD_WIDTH-1:0] load_value,
    input  logic                  load_valid,
    output logic [WORD_WIDTH-1:0] reference_value,
    differencer_binary_if.slave   bus
);

    localparam logic [WORD_WIDTH-1:0] WORD_ZERO = '0;
    localparam int PAYLOAD_WIDTH = WORD_WIDTH + 2;

    // A one-bit word has no room for a sign separate from its magnitude, so
    // the overflow flag would be meaningless; refuse to build it.
    if (WORD_WIDTH < 2) begin : g_width_check
        $error("differencer_binary: WORD_WIDTH must be 2 or more");
    end

    logic [WORD_WIDTH-1:0]    reference_q, reference_d;
    logic [WORD_WIDTH:0]      diffFull;
    logic [WORD_WIDTH-1:0]    difference;
    logic                     borrow;
    logic                     overflow;
    logic                     inTransfer;
    logic [PAYLOAD_WIDTH-1:0] payloadIn;
    logic [PAYLOAD_WIDTH-1:0] payloadOut;

    assign reference_value = reference_q;

    // sample_in_ready already carries the enable mask, so this is a real
    // transfer only on an enabled edge.
    assign inTransfer = bus.sample_in_valid & bus.sample_in_ready;

    // Subtract with one extra bit on top: the minimum possible result is
    // exactly -2^WORD_WIDTH and the maximum 2^WORD_WIDTH-1, so that top bit
    // is set precisely when sample_in < reference + borrow_in as unsigned.
    assign diffFull   = {1'b0, bus.sample_in} - {1'b0, reference_q}
                      - {WORD_ZERO, bus.borrow_in};
    assign difference = diffFull[WORD_WIDTH-1:0];
    assign borrow     = diffFull[WORD_WIDTH];

    // Signed overflow can only happen when the operands differ in sign, and
    // shows up as a result whose sign disagrees with the minuend.
    assign overflow = (bus.sample_in[WORD_WIDTH-1] != reference_q[WORD_WIDTH-1])
                   && (difference[WORD_WIDTH-1] != bus.sample_in[WORD_WIDTH-1]);

    assign payloadIn = {difference, borrow, overflow};

    // Reference update priority: clear beats load, load beats the sample.
    // A load in the same cycle as an accepted sample still lets that sample
    // be differenced against the old reference, since the payload above is
    // built from reference_q before this register moves.
    always_comb begin
        reference_d = reference_q;
        if (clear) begin
            reference_d = INITIAL_VALUE;
        end else if (load_valid) begin
            reference_d = load_value;
        end else if (inTransfer) begin
            reference_d = bus.sample_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reference_q <= INITIAL_VALUE;
        end else if (clock_enable) begin
            reference_q <= reference_d;
        end
    end

    Pipeline_Skid_Buffer #(
        .DATA_WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .clock          (clock),
        .reset_n        (reset_n),
        .clock_enable_i (clock_enable),
        .clear_i        (clear),
        .in_data_i      (payloadIn),
        .in_valid_i     (bus.sample_in_valid),
        .in_ready_o     (bus.sample_in_ready),
        .out_data_o     (payloadOut),
        .out_valid_o    (bus.difference_out_valid),
        .out_ready_i    (bus.difference_out_ready)
    );

    assign bus.difference_out  = payloadOut[PAYLOAD_WIDTH-1:2];
    assign bus.borrow_out      = payloadOut[1];
    assign bus.signed_overflow = payloadOut[0];

endmodule

// File: tb/tb_differencer_binary.sv
// ----------------------------------------------------------------------------
// tb_differencer_binary
//
// Purpose:
//   Directed self-checking bench for differencer_binary with WORD_WIDTH=8
//   and INITIAL_VALUE=0. Inputs change 1 time unit after each rising edge
//   and outputs are sampled at that same point, after the edge has settled.
// ----------------------------------------------------------------------------
module tb_differencer_binary;

    localparam int WW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          clockEnable;
    logic          clear;
    logic [WW-1:0] loadValue;
    logic          loadValid;
    logic [WW-1:0] referenceValue;

    int checks = 0;
    int errors = 0;

    differencer_binary_if #(.WORD_WIDTH(WW)) busIf ();

    differencer_binary #(
        .WORD_WIDTH    (WW),
        .INITIAL_VALUE (8'h00)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .clock_enable    (clockEnable),
        .clear           (clear),
        .load_value      (loadValue),
        .load_valid      (loadValid),
        .reference_value (referenceValue),
        .bus             (busIf)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive the sample stream and the consumer ready.
    task automatic applyStimulus(input logic inValid, input logic [WW-1:0] sample,
                                 input logic borrowIn, input logic outReady);
        busIf.sample_in_valid      = inValid;
        busIf.sample_in            = sample;
        busIf.borrow_in            = borrowIn;
        busIf.difference_out_ready = outReady;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks the whole output bundle at once.
    task automatic checkDiff(input string tag, input logic valid, input logic [WW-1:0] diff,
                             input logic borrow, input logic ovf);
        checkOutput({tag, ".valid"},  32'(busIf.difference_out_valid), 32'(valid));
        checkOutput({tag, ".diff"},   32'(busIf.difference_out),       32'(diff));
        checkOutput({tag, ".borrow"}, 32'(busIf.borrow_out),           32'(borrow));
        checkOutput({tag, ".ovf"},    32'(busIf.signed_overflow),      32'(ovf));
    endtask

    initial begin
        reset_n     = 1'b0;
        clockEnable = 1'b1;
        clear       = 1'b0;
        loadValue   = '0;
        loadValid   = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state
        #12;
        checkDiff("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset.ready", 32'(busIf.sample_in_ready), 32'd0);
        checkOutput("reset.ref",   32'(referenceValue),        32'h00);
        reset_n = 1'b1;
        tick();
        checkOutput("post_reset.ready", 32'(busIf.sample_in_ready), 32'd1);

        // Samples 5, 12, 7 with the consumer always ready
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
        tick();
        checkDiff("seq5", 1'b1, 8'h05, 1'b0, 1'b0);
        checkOutput("seq5.ref", 32'(referenceValue), 32'h05);
        applyStimulus(1'b1, 8'd12, 1'b0, 1'b1);
        tick();
        checkDiff("seq12", 1'b1, 8'h07, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd7, 1'b0, 1'b1);
        tick();
        checkDiff("seq7", 1'b1, 8'hFB, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
        checkOutput("seq.drain_valid", 32'(busIf.difference_out_valid), 32'd0);

        // Load 0x80, then sample 0x7F: signed overflow and borrow
        loadValue = 8'h80;
        loadValid = 1'b1;
        tick();
        loadValid = 1'b0;
        checkOutput("load80.ref",   32'(referenceValue),             32'h80);
        checkOutput("load80.valid", 32'(busIf.difference_out_valid), 32'd0);
        applyStimulus(1'b1, 8'h7F, 1'b0, 1'b1);
        tick();
        checkDiff("ovf", 1'b1, 8'hFF, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // Back-pressure: samples 1, 2, 3 with the consumer stalled
        loadValue = 8'h00;
        loadValid = 1'b1;
        tick();
        loadValid = 1'b0;
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
        tick();
        checkOutput("bp1.ready", 32'(busIf.sample_in_ready), 32'd1);
        checkDiff("bp1", 1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
        tick();
        checkOutput("bp2.ready", 32'(busIf.sample_in_ready), 32'd0);
        checkDiff("bp2.hold", 1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
        tick();
        checkOutput("bp3.ready", 32'(busIf.sample_in_ready), 32'd0);
        checkOutput("bp3.ref",   32'(referenceValue),        32'h02);
        checkDiff("bp3.hold", 1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b1);
        tick();
        checkDiff("bp.second", 1'b1, 8'h01, 1'b0, 1'b0);
        checkOutput("bp.ready_back", 32'(busIf.sample_in_ready), 32'd1);
        tick();
        checkDiff("bp.third", 1'b1, 8'h01, 1'b0, 1'b0);
        checkOutput("bp.ref3", 32'(referenceValue), 32'h03);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
        checkOutput("bp.drain_valid", 32'(busIf.difference_out_valid), 32'd0);

        // Same-cycle load and sample: old reference used, load wins
        loadValue = 8'h20;
        loadValid = 1'b1;
        tick();
        loadValue = 8'h10;
        applyStimulus(1'b1, 8'h30, 1'b0, 1'b1);
        tick();
        loadValid = 1'b0;
        checkDiff("loadsample", 1'b1, 8'h10, 1'b0, 1'b0);
        checkOutput("loadsample.ref", 32'(referenceValue), 32'h10);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // borrow_in with equal operands
        loadValue = 8'h03;
        loadValid = 1'b1;
        tick();
        loadValid = 1'b0;
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1);
        tick();
        checkDiff("borrowin", 1'b1, 8'hFF, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // Fill the buffer, then clear
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
        tick();
        checkOutput("full.ready", 32'(busIf.sample_in_ready), 32'd0);
        checkDiff("full", 1'b1, 8'h3D, 1'b0, 1'b0);
        clear = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checkDiff("clear", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("clear.ref",   32'(referenceValue),        32'h00);
        checkOutput("clear.ready", 32'(busIf.sample_in_ready), 32'd0);
        tick();
        checkOutput("clear_held.ready", 32'(busIf.sample_in_ready), 32'd0);
        clear = 1'b0;
        tick();
        checkOutput("clear_done.ready", 32'(busIf.sample_in_ready), 32'd1);

        // Clock enable low masks handshakes and freezes state
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
        tick();
        checkDiff("ce.before", 1'b1, 8'h05, 1'b0, 1'b0);
        clockEnable = 1'b0;
        applyStimulus(1'b1, 8'h09, 1'b0, 1'b1);
        #1;
        checkOutput("ce_off.valid", 32'(busIf.difference_out_valid), 32'd0);
        checkOutput("ce_off.ready", 32'(busIf.sample_in_ready),      32'd0);
        tick();
        clockEnable = 1'b1;
        applyStimulus(1'b1, 8'h09, 1'b0, 1'b0);
        #1;
        checkDiff("ce_on", 1'b1, 8'h05, 1'b0, 1'b0);
        checkOutput("ce_on.ref", 32'(referenceValue), 32'h05);

        // Asynchronous reset mid-stream
        reset_n = 1'b0;
        #1;
        checkDiff("async_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("async_reset.ready", 32'(busIf.sample_in_ready), 32'd0);
        checkOutput("async_reset.ref",   32'(referenceValue),        32'h00);
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("after_reset.ready", 32'(busIf.sample_in_ready),      32'd1);
        checkOutput("after_reset.valid", 32'(busIf.difference_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/differencer_binary.md
DIFFERENCER_BINARY -- requirements
Module: Differencer_Binary

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
- WORD_WIDTH, 0, sample/difference width in bits; legal values are 2 or more; elaboration SHALL fail below 2.
- INITIAL_VALUE, 0, reference value after reset or clear; WORD_WIDTH bits.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
- clock  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clock_enable  in  1  low freezes all state.
- clear  in  1  synchronous return to INITIAL_VALUE.
- sample_in  in  WORD_WIDTH  signed input sample.
- sample_in_valid  in  1  sample offered.
- sample_in_ready  out  1  sample accepted when high with valid; registered.
- load_value  in  WORD_WIDTH  new reference value.
- load_valid  in  1  one-cycle pulse; replaces the reference.
- borrow_in  in  1  extra 1 subtracted, for chaining.
- difference_out  out  WORD_WIDTH  sample_in minus reference minus borrow_in.
- difference_out_valid  out  1  difference offered.
- difference_out_ready  in  1  consumer accepts.
- borrow_out  out  1  unsigned borrow, travels with difference_out.
- signed_overflow  out  1  signed overflow, travels with difference_out.
- reference_value  out  WORD_WIDTH  current stored previous sample.

Function
REQ-003 An input transfer SHALL occur on a rising edge where sample_in_valid, sample_in_ready and clock_enable are all 1; an output transfer SHALL occur where difference_out_valid, difference_out_ready and clock_enable are all 1.
REQ-004 On an input transfer, the block SHALL compute D = sample_in - reference_value - borrow_in modulo 2^WORD_WIDTH, and reference_value SHALL become sample_in on the same edge.
REQ-005 borrow_out SHALL be 1 iff, treating all three operands as unsigned, sample_in < reference_value + borrow_in.
REQ-006 signed_overflow SHALL be 1 iff the signs of sample_in and reference_value differ and the sign of D differs from the sign of sample_in.
REQ-007 Latency SHALL be 1 cycle: D appears on difference_out with difference_out_valid on the edge after acceptance, provided the buffer was empty.
REQ-008 Output buffering SHALL be a 2-entry skid buffer with three states:
- EMPTY: valid=0, ready=1.
- BUSY: valid=1, ready=1.
- FULL: valid=1, ready=0.
REQ-009 Skid-buffer transitions SHALL be:
- EMPTY to BUSY on an input transfer.
- BUSY to FULL on an input transfer with no output transfer.
- BUSY to EMPTY on an output transfer with no input transfer.
- BUSY stays BUSY on simultaneous input and output transfers.
- FULL to BUSY on an output transfer.
REQ-010 Output SHALL be strictly in input order; no difference SHALL ever be dropped or duplicated.
REQ-011 difference_out, borrow_out and signed_overflow SHALL hold stable while difference_out_valid=1 and difference_out_ready=0.
REQ-012 load_valid=1 with clock_enable=1 SHALL set reference_value to load_value and SHALL produce no output.
REQ-013 Load and input transfer in the same cycle: D SHALL use the old reference_value, and reference_value SHALL become load_value (load wins the reference update).
REQ-014 clear=1 with clock_enable=1 SHALL have the following effects on the next edge:
- reference_value becomes INITIAL_VALUE.
- The skid buffer empties, discarding its contents.
- Outputs take their reset values.
- sample_in_ready drops to 0 and stays 0 while clear is high.
REQ-015 clear SHALL override both load_valid and any input transfer in the same cycle.
REQ-016 clock_enable=0 SHALL inhibit all transfers, loads and clears and hold every register, with sample_in_ready and difference_out_valid forced to 0.

Reset
REQ-017 When reset_n=0, the block SHALL asynchronously set:
- reference_value to INITIAL_VALUE.
- The skid buffer to EMPTY.
- difference_out, borrow_out and signed_overflow to 0.
- difference_out_valid to 0.
- sample_in_ready to 0.
REQ-018 sample_in_ready SHALL rise on the first clock edge after reset_n deasserts, if clock_enable=1.
REQ-019 A reset asserted mid-transfer SHALL lose that transfer, with no partial output.

Structure
REQ-020 Skid-buffer state encodings (EMPTY, BUSY, FULL) SHALL live in the shared package; WORD_ZERO SHALL be a local constant.
REQ-021 The output buffer SHALL be one sub-module, Pipeline_Skid_Buffer, carrying {difference_out, borrow_out, signed_overflow}.
REQ-022 The subtractor and reference register SHALL stay in the top level.

Verification
REQ-023 The bench SHALL cover these scenarios, all with WORD_WIDTH=8 and INITIAL_VALUE=0:
- Samples 5, 12, 7, out_ready=1 -> difference_out 0x05, 0x07, 0xFB; borrow_out 0, 0, 1; signed_overflow 0, 0, 0.
- load 0x80, then sample 0x7F -> difference_out 0xFF, signed_overflow=1, borrow_out=1.
- out_ready=0, offer samples 1, 2, 3 -> two accepted, then ready=0; release out_ready -> 0x01, 0x01 emitted, then 3 accepted, giving 0x01.
- reference 0x20, same-cycle load 0x10 and sample 0x30 -> difference_out 0x10, reference_value 0x10.
- borrow_in=1, reference 0x03, sample 0x03 -> difference_out 0xFF, borrow_out=1, signed_overflow=0.
- FULL buffer, pulse clear -> valid=0 next edge, reference_value 0x00; async reset_n low mid-stream -> all outputs 0 immediately.
